// File: rtl/z_core_pkg.sv
// Shared constants for the writeback/scoreboard slice: datapath width,
// register index width and load funct3 encodings.
package z_core_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREG      = 32;
  localparam int unsigned REG_IDX_W = $clog2(NREG);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/z_core_wb_fifo.sv
// Result buffer for the writeback port. It is a circular buffer whose head entry is
// always presented on o_head. Full and empty are derived from an occupancy counter.
module z_core_wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);
  // Full is judged before any same-cycle pop, so a full buffer never accepts.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= next_ptr(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= next_ptr(r_rptr);
      end
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

endmodule

// File: rtl/z_core_reg_wb.sv
// Writeback and scoreboard unit. It arbitrates ALU/LSU results, extends load data,
// and queues results for the register file write port. It flags RAW/WAW hazards to issue.
module z_core_reg_wb #(
  parameter int unsigned XLEN       = z_core_pkg::XLEN,
  parameter int unsigned NREG       = z_core_pkg::NREG,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic [$clog2(NREG)-1:0]  issue_rd,
  input  logic [$clog2(NREG)-1:0]  issue_rs1,
  input  logic [$clog2(NREG)-1:0]  issue_rs2,
  output logic                     hazard,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [$clog2(NREG)-1:0]  alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [$clog2(NREG)-1:0]  lsu_rd,
  input  logic [2:0]               lsu_funct3,
  input  logic [XLEN-1:0]          lsu_data,
  input  logic                     wb_hold,
  output logic                     write_enable,
  output logic [$clog2(NREG)-1:0]  rd,
  output logic [XLEN-1:0]          rd_in
);

  import z_core_pkg::*;

  localparam int unsigned IdxW = $clog2(NREG);
  localparam int unsigned EntW = IdxW + XLEN;

  logic            w_full;
  logic            w_empty;
  logic [EntW-1:0] w_head;
  logic            w_lsu_acc;
  logic            w_alu_acc;
  logic [IdxW-1:0] w_in_rd;
  logic [XLEN-1:0] w_in_data;
  logic            w_push;
  logic            w_fire;
  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;

  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3)
      F3_LB:   return {{(XLEN - 8){d[7]}}, d[7:0]};
      F3_LH:   return {{(XLEN - 16){d[15]}}, d[15:0]};
      F3_LBU:  return {{(XLEN - 8){1'b0}}, d[7:0]};
      F3_LHU:  return {{(XLEN - 16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  // LSU has fixed priority; the ALU only sees ready when no load is offered.
  assign lsu_ready = !w_full;
  assign alu_ready = !w_full && !lsu_valid;
  assign w_lsu_acc = lsu_valid && lsu_ready;
  assign w_alu_acc = alu_valid && alu_ready;

  always_comb begin
    w_in_rd   = alu_rd;
    w_in_data = alu_data;
    if (w_lsu_acc) begin
      w_in_rd   = lsu_rd;
      w_in_data = load_ext(lsu_funct3, lsu_data);
    end
  end

  // Writes to x0 complete the handshake but never occupy the buffer.
  assign w_push = (w_lsu_acc || w_alu_acc) && (w_in_rd != '0);

  z_core_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EntW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({w_in_rd, w_in_data}),
    .i_pop   (write_enable),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign write_enable = !w_empty && !wb_hold;
  assign rd           = w_head[EntW-1:XLEN];
  assign rd_in        = w_head[XLEN-1:0];

  assign hazard = ((issue_rs1 != '0) && r_pending[issue_rs1]) ||
                  ((issue_rs2 != '0) && r_pending[issue_rs2]) ||
                  ((issue_rd  != '0) && r_pending[issue_rd]);
  assign w_fire = issue_valid && !hazard;

  // Set is applied after clear so a same-edge issue to the committing register stays pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (write_enable) begin
      w_pending_nxt[rd] = 1'b0;
    end
    if (w_fire && (issue_rd != '0)) begin
      w_pending_nxt[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

endmodule

// File: tb/tb_z_core_reg_wb.sv
// Self-checking bench for z_core_reg_wb: directed corner cases, a load-extension
// vector table and a randomized run against a queue-based reference model.
module tb_z_core_reg_wb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        hazard;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_data;
  logic        wb_hold;
  logic        write_enable;
  logic [4:0]  rd;
  logic [31:0] rd_in;

  always #5 clk = ~clk;

  z_core_reg_wb #(
    .XLEN       (XLEN),
    .NREG       (NREG),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .hazard       (hazard),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_funct3   (lsu_funct3),
    .lsu_data     (lsu_data),
    .wb_hold      (wb_hold),
    .write_enable (write_enable),
    .rd           (rd),
    .rd_in        (rd_in)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] din;
    logic [31:0] dexp;
  } ext_vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t mq[$];
  bit   mpend[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [31:0] d);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] r;
    sb = d[7:0];
    sh = d[15:0];
    case (f3)
      3'd0:    r = sb;
      3'd1:    r = sh;
      3'd4:    r = {24'd0, d[7:0]};
      3'd5:    r = {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic bit ref_hazard();
    return (issue_rs1 != 0 && mpend[issue_rs1]) || (issue_rs2 != 0 && mpend[issue_rs2]) ||
           (issue_rd != 0 && mpend[issue_rd]);
  endfunction

  task automatic model_reset();
    mq.delete();
    foreach (mpend[i]) mpend[i] = 1'b0;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_funct3 = 0; lsu_data = 0;
    wb_hold = 0;
  endtask

  // Compare all outputs with the model for the current inputs, then advance one clock.
  task automatic model_cycle(input string tag);
    bit   full, exp_we, exp_haz, fire;
    res_t r;
    #1;
    full    = (mq.size() >= DEPTH);
    exp_we  = (mq.size() > 0) && !wb_hold;
    exp_haz = ref_hazard();
    chk({tag, ".we"}, {31'd0, write_enable}, {31'd0, exp_we});
    chk({tag, ".lsu_ready"}, {31'd0, lsu_ready}, {31'd0, !full});
    chk({tag, ".alu_ready"}, {31'd0, alu_ready}, {31'd0, !full && !lsu_valid});
    chk({tag, ".hazard"}, {31'd0, hazard}, {31'd0, exp_haz});
    if (mq.size() > 0) begin
      chk({tag, ".rd"}, {27'd0, rd}, {27'd0, mq[0].rd});
      chk({tag, ".rd_in"}, rd_in, mq[0].data);
    end
    fire = issue_valid && !exp_haz;
    @(posedge clk);
    if (exp_we) begin
      mpend[mq[0].rd] = 1'b0;
      void'(mq.pop_front());
    end
    if (lsu_valid && !full) begin
      r.rd = lsu_rd; r.data = ref_ext(lsu_funct3, lsu_data);
      if (r.rd != 0) mq.push_back(r);
    end else if (alu_valid && !full) begin
      r.rd = alu_rd; r.data = alu_data;
      if (r.rd != 0) mq.push_back(r);
    end
    if (fire && issue_rd != 0) mpend[issue_rd] = 1'b1;
    #1;
  endtask

  ext_vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int n_acc;
    int k;
    int guard;

    vecs[0] = '{3'b000, 32'h0000_00F0, 32'hFFFF_FFF0};
    vecs[1] = '{3'b100, 32'h0000_00F0, 32'h0000_00F0};
    vecs[2] = '{3'b001, 32'h0000_8001, 32'hFFFF_8001};
    vecs[3] = '{3'b101, 32'h1234_8001, 32'h0000_8001};
    vecs[4] = '{3'b010, 32'h89AB_CDEF, 32'h89AB_CDEF};
    vecs[5] = '{3'b011, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[6] = '{3'b000, 32'h1234_567F, 32'h0000_007F};
    vecs[7] = '{3'b001, 32'hFFFF_7FFF, 32'h0000_7FFF};
    vecs[8] = '{3'b110, 32'hFFFF_FF80, 32'hFFFF_FF80};

    idle_inputs();
    model_reset();
    reset = 1'b0;
    #1;
    chk("reset.we", {31'd0, write_enable}, 32'd0);
    chk("reset.rd", {27'd0, rd}, 32'd0);
    chk("reset.rd_in", rd_in, 32'd0);
    chk("reset.hazard", {31'd0, hazard}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;

    // Issue rd=5 then ALU writes 15 to x5.
    issue_valid = 1; issue_rd = 5;
    model_cycle("t2_issue");
    issue_valid = 0; issue_rd = 0; issue_rs1 = 5;
    alu_valid = 1; alu_rd = 5; alu_data = 15;
    #1;
    chk("t2_hazard_set", {31'd0, hazard}, 32'd1);
    model_cycle("t2_accept");
    alu_valid = 0;
    #1;
    chk("t2_we", {31'd0, write_enable}, 32'd1);
    chk("t2_rd", {27'd0, rd}, 32'd5);
    chk("t2_rd_in", rd_in, 32'd15);
    chk("t2_hazard_hold", {31'd0, hazard}, 32'd1);
    model_cycle("t2_commit");
    chk("t2_hazard_clear", {31'd0, hazard}, 32'd0);
    chk("t2_we_off", {31'd0, write_enable}, 32'd0);
    issue_rs1 = 0;

    // Load extension table.
    for (int i = 0; i < 9; i++) begin
      lsu_valid = 1; lsu_rd = 3; lsu_funct3 = vecs[i].f3; lsu_data = vecs[i].din;
      model_cycle("t3_acc");
      lsu_valid = 0;
      #1;
      chk($sformatf("t3_ext[%0d]", i), rd_in, vecs[i].dexp);
      model_cycle("t3_commit");
    end

    // LSU and ALU together: LSU first.
    lsu_valid = 1; lsu_rd = 9; lsu_funct3 = 3'b010; lsu_data = 32'h99;
    alu_valid = 1; alu_rd = 8; alu_data = 32'h88;
    #1;
    chk("t4_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    chk("t4_alu_ready", {31'd0, alu_ready}, 32'd0);
    model_cycle("t4_a");
    lsu_valid = 0;
    #1;
    chk("t4_alu_ready2", {31'd0, alu_ready}, 32'd1);
    chk("t4_rd_first", {27'd0, rd}, 32'd9);
    model_cycle("t4_b");
    alu_valid = 0;
    #1;
    chk("t4_rd_second", {27'd0, rd}, 32'd8);
    chk("t4_data_second", rd_in, 32'h88);
    model_cycle("t4_c");
    chk("t4_drained", {31'd0, write_enable}, 32'd0);

    // Held write port with a continuous ALU stream.
    wb_hold = 1; alu_valid = 1; n_acc = 0; k = 0;
    for (int i = 0; i < 4; i++) begin
      alu_rd = 5'(10 + k); alu_data = 32'h500 + k;
      #1;
      if (alu_ready) begin
        n_acc++;
        k++;
      end
      model_cycle("t5_hold");
    end
    chk("t5_accepts", n_acc, DEPTH);
    chk("t5_ready_low", {31'd0, alu_ready}, 32'd0);
    wb_hold = 0; alu_valid = 0;
    for (int j = 0; j < int'(DEPTH); j++) begin
      #1;
      chk("t5_order_rd", {27'd0, rd}, 32'(10 + j));
      chk("t5_order_data", rd_in, 32'h500 + j);
      model_cycle("t5_release");
    end
    chk("t5_empty", {31'd0, write_enable}, 32'd0);

    // rd=0 results and issues.
    alu_valid = 1; alu_rd = 0; alu_data = 40;
    #1;
    chk("t6_alu_ready", {31'd0, alu_ready}, 32'd1);
    model_cycle("t6_acc");
    alu_valid = 0;
    #1;
    chk("t6_no_write", {31'd0, write_enable}, 32'd0);
    issue_valid = 1; issue_rd = 0;
    model_cycle("t6_issue");
    issue_valid = 0;
    model_cycle("t6_after");

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      issue_rs1   = 5'($urandom_range(0, 7));
      issue_rs2   = 5'($urandom_range(0, 7));
      alu_valid   = 1'($urandom_range(0, 1));
      alu_rd      = 5'($urandom_range(0, 7));
      alu_data    = $urandom;
      lsu_valid   = ($urandom_range(0, 2) == 0);
      lsu_rd      = 5'($urandom_range(0, 7));
      lsu_funct3  = 3'($urandom_range(0, 7));
      lsu_data    = $urandom;
      wb_hold     = ($urandom_range(0, 3) == 0);
      model_cycle("rand");
    end
    idle_inputs();
    guard = 0;
    while (mq.size() > 0 && guard < 20) begin
      model_cycle("drain");
      guard++;
    end
    chk("drain_bound", 32'(mq.size()), 32'd0);
    for (int r = 1; r < 32; r++) begin
      issue_rs1 = 5'(r);
      #1;
      chk($sformatf("final_pend[%0d]", r), {31'd0, hazard}, {31'd0, mpend[r]});
    end
    idle_inputs();

    // Reset mid-stream with two results queued behind a hold.
    issue_valid = 1; issue_rd = 12;
    model_cycle("t1_issue");
    issue_valid = 0; issue_rd = 0; wb_hold = 1;
    alu_valid = 1; alu_rd = 12; alu_data = 1;
    model_cycle("t1_q0");
    alu_rd = 13; alu_data = 2;
    model_cycle("t1_q1");
    alu_valid = 0; issue_rs1 = 12;
    #1;
    chk("t1_full", {31'd0, alu_ready}, 32'd0);
    chk("t1_pending", {31'd0, hazard}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t1_we", {31'd0, write_enable}, 32'd0);
    chk("t1_rd", {27'd0, rd}, 32'd0);
    chk("t1_rd_in", rd_in, 32'd0);
    chk("t1_hazard", {31'd0, hazard}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1; wb_hold = 0;
    model_cycle("t1_post");
    model_cycle("t1_post2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
